dmem_responder: RTL and testbench

Multi-cycle data-memory responder that sits on the memory side of the CPU's load/store port, in place of the single-cycle data memory. It accepts one word read or write request at a time through a valid/ready handshake. Each request completes after a fixed configurable latency, and the block then returns a one-cycle response. This is the latency-bearing memory model that the stall logic and the later cache are built and tested against.

---
 rtl/dmem_responder.sv | 210 +++++++++++++++++++++
 tb/tb_dmem_responder.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_responder.sv
// -----------------------------------------------------------------------------
// dmem_responder
//
// Multi-cycle data-memory responder for the CPU load/store port. It takes one
// 16-bit word read or write at a time through a valid/ready handshake. After
// LATENCY cycles it returns a single-cycle response pulse carrying the read
// data, which is zero for writes.
//
// Parameters:
//   LATENCY     cycles from acceptance to the response cycle (1..15)
//   WORDS_LOG2  log2 of the storage depth in 16-bit words
//
// Ports:
//   clk          clock, rising edge
//   rst_n        synchronous active-low reset
//   req_valid    requester presents a request
//   req_ready    block is IDLE and will accept a request this cycle
//   req_wr       1 = write, 0 = read
//   req_addr     byte address (word index is req_addr[WORDS_LOG2:1])
//   req_wdata    write data
//   resp_valid   one-cycle completion pulse (reads and writes)
//   resp_rdata   read data, 0 for writes and errored requests
//   resp_err     misaligned request rejected (qualified by resp_valid)
//   busy         a request is in flight
//
// Optional feature macro: DMEM_ALIGN_CHECK_EN
//   When defined, requests with req_addr[0] = 1 run the full latency, make no
//   array access, and complete with resp_err = 1. When undefined, address
//   bit 0 is ignored and resp_err is tied low.
// -----------------------------------------------------------------------------
module dmem_responder #(
  parameter int unsigned LATENCY    = 4,
  parameter int unsigned WORDS_LOG2 = 15
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_wr,
  input  logic [15:0] req_addr,
  input  logic [15:0] req_wdata,
  output logic        resp_valid,
  output logic [15:0] resp_rdata,
  output logic        resp_err,
  output logic        busy
);

  localparam int unsigned DEPTH = 1 << WORDS_LOG2;

  // The counter is loaded at acceptance. It counts the WAIT cycles that
  // remain after the first one, so LATENCY-2 gives exactly LATENCY edges
  // from acceptance to the edge that raises resp_valid.
  localparam logic [3:0] CNT_LOAD = (LATENCY >= 2) ? 4'(LATENCY - 2) : 4'd0;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        wr_q, wr_d;
  logic [15:0] addr_q, addr_d;
  logic [15:0] wdata_q, wdata_d;
  logic [15:0] rdata_q, rdata_d;

  logic [15:0] mem_array [DEPTH];

  logic                  enter_resp;
  logic                  acc_from_req;
  logic                  acc_wr;
  logic [15:0]           acc_addr;
  logic [15:0]           acc_wdata;
  logic [WORDS_LOG2-1:0] word_idx;
  logic                  acc_mis;
  logic                  mem_we;

  // Control FSM: IDLE accepts, WAIT counts down, RESP is the single response
  // cycle. Inputs are only looked at in IDLE.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    wr_d       = wr_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    enter_resp = 1'b0;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          wr_d    = req_wr;
          addr_d  = req_addr;
          wdata_d = req_wdata;
          if (LATENCY == 1) begin
            state_d    = RESP;
            cnt_d      = 4'd0;
            enter_resp = 1'b1;
          end else begin
            state_d = WAIT;
            cnt_d   = CNT_LOAD;
          end
        end
      end
      WAIT: begin
        if (cnt_q == 4'd0) begin
          state_d    = RESP;
          enter_resp = 1'b1;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // The access happens on the edge that enters RESP. With LATENCY = 1 that is
  // the accepting edge itself, so the live request fields are used instead of
  // the latched ones.
  always_comb begin
    acc_from_req = (state_q == IDLE);
    acc_wr       = acc_from_req ? req_wr    : wr_q;
    acc_addr     = acc_from_req ? req_addr  : addr_q;
    acc_wdata    = acc_from_req ? req_wdata : wdata_q;
    word_idx     = acc_addr[WORDS_LOG2:1];
  end

`ifdef DMEM_ALIGN_CHECK_EN
  logic err_q, err_d;

  assign acc_mis = acc_addr[0];

  // The error flag is captured together with the read data on RESP entry and
  // held until the next response.
  always_comb begin
    err_d = err_q;
    if (enter_resp) begin
      err_d = acc_mis;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      err_q <= 1'b0;
    end else begin
      err_q <= err_d;
    end
  end

  assign resp_err = err_q;
`else
  logic unused_addr_bit;

  assign unused_addr_bit = acc_addr[0];
  assign acc_mis         = 1'b0;
  assign resp_err        = 1'b0;
`endif

  assign mem_we = enter_resp & acc_wr & ~acc_mis;

  // Read data is loaded only on RESP entry. Writes and rejected requests
  // report zero.
  always_comb begin
    rdata_d = rdata_q;
    if (enter_resp) begin
      if (acc_wr || acc_mis) begin
        rdata_d = 16'h0000;
      end else begin
        rdata_d = mem_array[word_idx];
      end
    end
  end

  // Control and response registers. Reset drops any in-flight request.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      wr_q    <= 1'b0;
      addr_q  <= 16'h0000;
      wdata_q <= 16'h0000;
      rdata_q <= 16'h0000;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      wr_q    <= wr_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
    end
  end

  // Storage array. Its contents survive reset, but a write whose commit edge
  // coincides with reset is suppressed so an aborted write leaves no trace.
  always_ff @(posedge clk) begin
    if (rst_n && mem_we) begin
      mem_array[word_idx] <= acc_wdata;
    end
  end

  assign req_ready  = (state_q == IDLE);
  assign busy       = (state_q != IDLE);
  assign resp_valid = (state_q == RESP);
  assign resp_rdata = rdata_q;

endmodule

// File: tb/tb_dmem_responder.sv
// -----------------------------------------------------------------------------
// tb_dmem_responder
//
// Self-checking bench for dmem_responder. Two instances run side by side, one
// with LATENCY = 4 and one with LATENCY = 1. They share the request buses but
// have separate valid lines. Expected data comes from a per-instance word
// memory model (associative array keyed by word index). Expected timing comes
// from the latency rule: the response appears LATENCY edges after acceptance.
// -----------------------------------------------------------------------------
module tb_dmem_responder;

`ifdef DMEM_ALIGN_CHECK_EN
  localparam bit ALIGN = 1'b1;
`else
  localparam bit ALIGN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        reqWr;
  logic [15:0] reqAddr;
  logic [15:0] reqWdata;
  logic        v4, v1;

  logic        rdy4, rv4, err4, busy4;
  logic [15:0] rdata4;
  logic        rdy1, rv1, err1, busy1;
  logic [15:0] rdata1;

  int total = 0;
  int bad   = 0;

  logic [15:0] mdl4 [int];
  logic [15:0] mdl1 [int];

  always #5 clk = ~clk;

  dmem_responder #(.LATENCY(4), .WORDS_LOG2(15)) dut4 (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (v4),
    .req_ready  (rdy4),
    .req_wr     (reqWr),
    .req_addr   (reqAddr),
    .req_wdata  (reqWdata),
    .resp_valid (rv4),
    .resp_rdata (rdata4),
    .resp_err   (err4),
    .busy       (busy4)
  );

  dmem_responder #(.LATENCY(1), .WORDS_LOG2(15)) dut1 (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (v1),
    .req_ready  (rdy1),
    .req_wr     (reqWr),
    .req_addr   (reqAddr),
    .req_wdata  (reqWdata),
    .resp_valid (rv1),
    .resp_rdata (rdata1),
    .resp_err   (err1),
    .busy       (busy1)
  );

  function automatic logic getRv(int s);
    return (s == 1) ? rv1 : rv4;
  endfunction

  function automatic logic getRdy(int s);
    return (s == 1) ? rdy1 : rdy4;
  endfunction

  function automatic logic getBusy(int s);
    return (s == 1) ? busy1 : busy4;
  endfunction

  function automatic logic getErr(int s);
    return (s == 1) ? err1 : err4;
  endfunction

  function automatic logic [15:0] getRdata(int s);
    return (s == 1) ? rdata1 : rdata4;
  endfunction

  // Single comparison point: counts every check and reports mismatches.
  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Drive the shared request fields and the valid of the selected instance.
  task automatic applyStimulus(input int s, input logic valid, input logic wr,
                               input logic [15:0] addr, input logic [15:0] wdata);
    reqWr    = wr;
    reqAddr  = addr;
    reqWdata = wdata;
    if (s == 1) v1 = valid;
    else        v4 = valid;
  endtask

  // One complete transaction on an idle instance: the expected response comes
  // from the word model, and the response must arrive exactly LATENCY edges
  // after the accepting edge. Leaves the instance back in IDLE.
  task automatic runTxn(input int s, input logic wr, input logic [15:0] addr,
                        input logic [15:0] wdata, input string tag);
    int          lat;
    int          edges;
    int          idx;
    logic        mis;
    logic [15:0] expData;
    lat = (s == 1) ? 1 : 4;
    idx = int'(addr >> 1);
    mis = ALIGN && addr[0];
    if (wr || mis)    expData = 16'h0000;
    else if (s == 1)  expData = mdl1[idx];
    else              expData = mdl4[idx];

    checkOutput($sformatf("%s_ready_idle", tag), 32'(getRdy(s)), 32'd1);
    applyStimulus(s, 1'b1, wr, addr, wdata);
    @(posedge clk);
    #1;
    applyStimulus(s, 1'b0, 1'b0, 16'h0000, 16'h0000);
    edges = 1;
    while (!getRv(s) && edges < 40) begin
      checkOutput($sformatf("%s_ready_wait", tag), 32'(getRdy(s)), 32'd0);
      @(posedge clk);
      #1;
      edges++;
    end
    checkOutput($sformatf("%s_latency", tag), 32'(edges), 32'(lat));
    checkOutput($sformatf("%s_rdata", tag), 32'(getRdata(s)), 32'(expData));
    checkOutput($sformatf("%s_err", tag), 32'(getErr(s)), 32'(mis));
    checkOutput($sformatf("%s_ready_resp", tag), 32'(getRdy(s)), 32'd0);
    checkOutput($sformatf("%s_busy_resp", tag), 32'(getBusy(s)), 32'd1);
    if (wr && !mis) begin
      if (s == 1) mdl1[idx] = wdata;
      else        mdl4[idx] = wdata;
    end
    @(posedge clk);
    #1;
    checkOutput($sformatf("%s_pulse_end", tag), 32'(getRv(s)), 32'd0);
  endtask

  initial begin
    int          rs;
    logic        rw;
    logic [15:0] ra;
    logic [15:0] heldA;
    logic        rdyBefore;
    int          lastAcc;
    int          accCount;
    int          respCount;
    logic [15:0] expQ [$];

    // Reset with requests presented: none of them may be accepted.
    rst_n = 1'b0;
    applyStimulus(4, 1'b1, 1'b1, 16'h0030, 16'h1111);
    v1 = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    applyStimulus(4, 1'b0, 1'b0, 16'h0000, 16'h0000);
    v1 = 1'b0;
    checkOutput("rst_ready4", 32'(rdy4), 32'd1);
    checkOutput("rst_busy4", 32'(busy4), 32'd0);
    checkOutput("rst_rv4", 32'(rv4), 32'd0);
    checkOutput("rst_rdata4", 32'(rdata4), 32'h0000);
    checkOutput("rst_err4", 32'(err4), 32'd0);
    checkOutput("rst_ready1", 32'(rdy1), 32'd1);
    checkOutput("rst_busy1", 32'(busy1), 32'd0);
    checkOutput("rst_rdata1", 32'(rdata1), 32'h0000);
    for (int i = 0; i < 6; i++) begin
      @(posedge clk);
      #1;
      checkOutput("rst_no_resp4", 32'(rv4), 32'd0);
      checkOutput("rst_no_resp1", 32'(rv1), 32'd0);
    end

    // Write then read, LATENCY = 4.
    runTxn(4, 1'b1, 16'h0010, 16'hBEEF, "wr_beef");
    runTxn(4, 1'b0, 16'h0010, 16'h0000, "rd_beef");
    checkOutput("rd_beef_value", 32'(rdata4), 32'h0000BEEF);

    // LATENCY = 1 write then read.
    runTxn(1, 1'b1, 16'h0002, 16'h1234, "l1_wr");
    runTxn(1, 1'b0, 16'h0002, 16'h0000, "l1_rd");
    checkOutput("l1_rd_value", 32'(rdata1), 32'h00001234);

    // Held request stream: one acceptance every LATENCY+1 edges.
    runTxn(4, 1'b1, 16'h0040, 16'hA0A0, "held_pre_a");
    runTxn(4, 1'b1, 16'h0042, 16'hB1B1, "held_pre_b");
    heldA = 16'h0040;
    applyStimulus(4, 1'b1, 1'b0, heldA, 16'h0000);
    lastAcc   = -1;
    accCount  = 0;
    respCount = 0;
    for (int e = 0; e < 33; e++) begin
      rdyBefore = rdy4;
      @(posedge clk);
      #1;
      if (e >= 27) v4 = 1'b0;
      if (rdyBefore && e < 27) begin
        if (lastAcc >= 0) checkOutput("held_interval", 32'(e - lastAcc), 32'd5);
        lastAcc = e;
        accCount++;
        expQ.push_back(mdl4[int'(reqAddr >> 1)]);
        reqAddr = (reqAddr == 16'h0040) ? 16'h0042 : 16'h0040;
      end
      if (rv4) begin
        respCount++;
        if (expQ.size() > 0) checkOutput("held_rdata", 32'(rdata4), 32'(expQ.pop_front()));
        else                 checkOutput("held_extra_resp", 32'(respCount), 32'(accCount));
      end
    end
    v4 = 1'b0;
    checkOutput("held_acc_count", 32'(accCount), 32'd6);
    checkOutput("held_resp_count", 32'(respCount), 32'(accCount));
    @(posedge clk);
    #1;

    // Reset in the middle of a write: the array keeps the old word.
    runTxn(4, 1'b1, 16'h0020, 16'h5555, "pre_5555");
    applyStimulus(4, 1'b1, 1'b1, 16'h0020, 16'hAAAA);
    @(posedge clk);
    #1;
    applyStimulus(4, 1'b0, 1'b0, 16'h0000, 16'h0000);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    checkOutput("abort_busy", 32'(busy4), 32'd0);
    for (int i = 0; i < 6; i++) begin
      @(posedge clk);
      #1;
      checkOutput("abort_no_resp", 32'(rv4), 32'd0);
    end
    runTxn(4, 1'b0, 16'h0020, 16'h0000, "abort_rd");
    checkOutput("abort_rd_value", 32'(rdata4), 32'h00005555);

    // Odd address handling.
    runTxn(4, 1'b1, 16'h0010, 16'h1111, "odd_pre");
`ifdef DMEM_ALIGN_CHECK_EN
    runTxn(4, 1'b0, 16'h0011, 16'h0000, "odd_rd");
    checkOutput("odd_rd_err", 32'(err4), 32'd1);
    runTxn(4, 1'b1, 16'h0011, 16'h7777, "odd_wr");
    runTxn(4, 1'b0, 16'h0010, 16'h0000, "odd_keep");
    checkOutput("odd_keep_value", 32'(rdata4), 32'h00001111);
`else
    runTxn(4, 1'b0, 16'h0011, 16'h0000, "odd_rd");
    checkOutput("odd_rd_value", 32'(rdata4), 32'h00001111);
`endif

    // Randomised traffic over a small pool, both instances.
    for (int k = 0; k < 8; k++) begin
      runTxn(4, 1'b1, 16'(16'h0100 + 2 * k), 16'($urandom), "pool4");
      runTxn(1, 1'b1, 16'(16'h0100 + 2 * k), 16'($urandom), "pool1");
    end
    for (int i = 0; i < 24; i++) begin
      rs = ($urandom_range(0, 1) == 1) ? 1 : 4;
      rw = 1'($urandom_range(0, 1));
      ra = 16'(16'h0100 + 2 * $urandom_range(0, 7) + $urandom_range(0, 1));
      runTxn(rs, rw, ra, 16'($urandom), "rand");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
